seq_restoring_divider: RTL and testbench



---
 rtl/div_pkg.sv | 20 ++
 rtl/seq_restoring_divider_if.sv | 26 ++
 rtl/div_step.sv | 32 +++
 rtl/seq_restoring_divider.sv | 142 ++++++++++++++
 tb/tb_seq_restoring_divider.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
//   state_e     : FSM encoding (StIdle, StCalc, StFinish)
//   cnt_width() : iteration-counter width for a given operand width
//   DivZeroQuot : all-ones pattern, sliced to WIDTH for the divide-by-zero quotient
package div_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StCalc   = 2'd1,
        StFinish = 2'd2
    } state_e;

    // Counter must be able to hold 0..WIDTH-1; one extra value keeps WIDTH=2^n safe.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    localparam logic [63:0] DivZeroQuot = '1;

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/done handshake and operand/result bus of the sequential divider.
//   start, a, b                             : controller -> divider
//   ready, done, quotient, remainder, div_zero : divider -> controller
// Modports: master (controller side), slave (divider side).
interface seq_restoring_divider_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, a, b,
        input  ready, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, a, b,
        output ready, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
//   r       : partial remainder (WIDTH+1 bits) before this iteration
//   dvd_msb : dividend bit shifted into the partial remainder
//   dvs     : divisor
//   r_next  : partial remainder after trial subtract and restore select
//   q_bit   : quotient bit produced (1 = subtract kept)
module div_step #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH:0]   r,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH:0]   r_next,
    output logic             q_bit
);
    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] diff;
    logic           carry;
    logic           unused_r_msb;

    // Top bit of r is always shifted out; kept in the port for a uniform R width.
    assign unused_r_msb = r[WIDTH];

    always_comb begin
        r_sh = {r[WIDTH-1:0], dvd_msb};
        // r_sh - {0,dvs} done as add of inverted divisor with carry-in 1;
        // carry out set means the difference is non-negative.
        {carry, diff} = {1'b0, r_sh} + {1'b0, 1'b1, ~dvs} + (WIDTH + 2)'(1);
        r_next = carry ? diff : r_sh;
        q_bit  = carry;
    end
endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/done handshake.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : seq_restoring_divider_if.slave (start/a/b in, ready/done/results out)
// Optional: define DIV_SIGNED_EN for two's-complement truncating division;
// undefined gives a purely unsigned divider.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input logic                    clk,
    input logic                    rst,
    seq_restoring_divider_if.slave bus
);
    localparam int unsigned CntW = cnt_width(WIDTH);

    state_e           state;
    logic [WIDTH-1:0] dvd_q;     // dividend, shifted left; refills with quotient bits
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   r_q;
    logic [CntW-1:0]  cnt_q;
    logic             ready_q;
    logic             done_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             dz_q;

    logic [WIDTH:0]   r_next;
    logic             q_bit;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] quot_fin;
    logic [WIDTH-1:0] rem_fin;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r       (r_q),
        .dvd_msb (dvd_q[WIDTH-1]),
        .dvs     (dvs_q),
        .r_next  (r_next),
        .q_bit   (q_bit)
    );

`ifdef DIV_SIGNED_EN
    logic neg_quot_q;
    logic neg_rem_q;

    always_comb begin
        a_mag = bus.a[WIDTH-1] ? (~bus.a + WIDTH'(1)) : bus.a;
        b_mag = bus.b[WIDTH-1] ? (~bus.b + WIDTH'(1)) : bus.b;
        // Sign fix-up folded into the FINISH load; most-negative / -1 wraps naturally.
        quot_fin = {dvd_q[WIDTH-2:0], q_bit};
        rem_fin  = r_next[WIDTH-1:0];
        if (neg_quot_q) quot_fin = ~quot_fin + WIDTH'(1);
        if (neg_rem_q)  rem_fin  = ~rem_fin + WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (state == StIdle && bus.start) begin
            neg_quot_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            neg_rem_q  <= bus.a[WIDTH-1];
        end
    end
`else
    always_comb begin
        a_mag    = bus.a;
        b_mag    = bus.b;
        quot_fin = {dvd_q[WIDTH-2:0], q_bit};
        rem_fin  = r_next[WIDTH-1:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StIdle;
            dvd_q   <= '0;
            dvs_q   <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.start) begin
                        dvd_q   <= a_mag;
                        dvs_q   <= b_mag;
                        r_q     <= '0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        dz_q    <= 1'b0;
                        if (bus.b == '0) begin
                            // No iterations: results are known at the accept edge.
                            state  <= StFinish;
                            quot_q <= DivZeroQuot[WIDTH-1:0];
                            rem_q  <= bus.a;
                            dz_q   <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            state <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    r_q   <= r_next;
                    dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state  <= StFinish;
                        quot_q <= quot_fin;
                        rem_q  <= rem_fin;
                        done_q <= 1'b1;
                    end
                end
                StFinish: begin
                    state   <= StIdle;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= StIdle;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed self-checking bench for seq_restoring_divider at WIDTH=4.
// Build with DIV_SIGNED_EN defined to exercise the signed variant.
module tb_seq_restoring_divider;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    seq_restoring_divider_if #(.WIDTH(4)) bus ();

    seq_restoring_divider #(
        .WIDTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered and left at a negedge with the divider in IDLE.
    task automatic run_div(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] eq, input logic [3:0] er, input logic edz,
                           input int elat);
        int n;
        bus.a = a;
        bus.b = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        check({tag, "_ready_low"}, 32'(bus.ready), 32'd0);
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(elat));
        check({tag, "_quot"}, 32'(bus.quotient), 32'(eq));
        check({tag, "_rem"}, 32'(bus.remainder), 32'(er));
        check({tag, "_dz"}, 32'(bus.div_zero), 32'(edz));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_ready_back"}, 32'(bus.ready), 32'd1);
    endtask

    initial begin
        int n;
        int dones;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_quot", 32'(bus.quotient), 32'd0);
        check("rst_rem", 32'(bus.remainder), 32'd0);
        check("rst_dz", 32'(bus.div_zero), 32'd0);

`ifdef DIV_SIGNED_EN
        run_div("s_m7_2", 4'b1001, 4'd2, 4'b1101, 4'b1111, 1'b0, 5);
        run_div("s_m8_m1", 4'b1000, 4'b1111, 4'b1000, 4'd0, 1'b0, 5);
        run_div("s_7_m2", 4'd7, 4'b1110, 4'b1101, 4'd1, 1'b0, 5);
        run_div("s_m7_m2", 4'b1001, 4'b1110, 4'd3, 4'b1111, 1'b0, 5);
        run_div("s_m7_0", 4'b1001, 4'd0, 4'b1111, 4'b1001, 1'b1, 1);
        run_div("s_6_3", 4'd6, 4'd3, 4'd2, 4'd0, 1'b0, 5);
`else
        run_div("u_13_3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 5);
        run_div("u_7_0", 4'd7, 4'd0, 4'd15, 4'd7, 1'b1, 1);

        // Results and div_zero hold through IDLE; next accept clears only div_zero.
        repeat (3) @(negedge clk);
        check("hold_quot", 32'(bus.quotient), 32'd15);
        check("hold_dz", 32'(bus.div_zero), 32'd1);
        bus.a = 4'd2;
        bus.b = 4'd5;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("accept_dz_clear", 32'(bus.div_zero), 32'd0);
        check("accept_quot_held", 32'(bus.quotient), 32'd15);
        check("accept_rem_held", 32'(bus.remainder), 32'd7);
        n = 1;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("u_2_5_latency", 32'(n), 32'd5);
        check("u_2_5_quot", 32'(bus.quotient), 32'd0);
        check("u_2_5_rem", 32'(bus.remainder), 32'd2);
        @(negedge clk);

        run_div("u_15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5);

        // Start during CALC must be ignored.
        bus.a = 4'd13;
        bus.b = 4'd3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.a = 4'd9;
        bus.b = 4'd2;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = 4'd0;
        bus.b = 4'd0;
        n = 3;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ign_latency", 32'(n), 32'd5);
        check("ign_quot", 32'(bus.quotient), 32'd4);
        check("ign_rem", 32'(bus.remainder), 32'd1);
        @(negedge clk);

        // Reset during CALC aborts: outputs cleared, no done afterwards.
        bus.a = 4'd13;
        bus.b = 4'd3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_quot", 32'(bus.quotient), 32'd0);
        check("abort_rem", 32'(bus.remainder), 32'd0);
        check("abort_dz", 32'(bus.div_zero), 32'd0);
        check("abort_ready", 32'(bus.ready), 32'd1);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done) dones++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(dones), 32'd0);

        // Full sweep, starting again as soon as ready returns.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                if (ib == 0) begin
                    run_div($sformatf("sw_%0d_%0d", ia, ib), 4'(ia), 4'(ib), 4'd15, 4'(ia),
                            1'b1, 1);
                end else begin
                    run_div($sformatf("sw_%0d_%0d", ia, ib), 4'(ia), 4'(ib), 4'(ia / ib),
                            4'(ia % ib), 1'b0, 5);
                end
            end
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
